ref_clk_select: RTL and testbench

REF_CLK_SELECT -- requirements
Module: ref_clk_select

---
 rtl/ref_clk_select.sv | 210 +++++++++++++++++++++
 tb/tb_ref_clk_select.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ref_clk_select.sv
// Reference clock selector.
// Each reference channel's toggle signal is edge-counted over a fixed gate
// window of clk cycles. A channel qualifies after VALID_GATES consecutive
// in-window gates. The highest-index eligible channel is chosen, subject to
// a holdoff between voluntary switches. Loss of the selected channel, or a
// manual override, switches immediately.

// Per-channel frequency measurement and qualification.
module ref_clk_select_ch #(
    parameter int COUNT_WIDTH = 8,
    parameter int CNT_MIN     = 8,
    parameter int CNT_MAX     = 12,
    parameter int VALID_GATES = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ref_toggle,
    input  logic                   gate_tick,
    output logic [COUNT_WIDTH-1:0] ch_count,
    output logic                   ch_valid
);

    localparam int GOOD_W = $clog2(VALID_GATES + 1);
    localparam logic [COUNT_WIDTH-1:0] WIN_LO   = COUNT_WIDTH'(CNT_MIN);
    localparam logic [COUNT_WIDTH-1:0] WIN_HI   = COUNT_WIDTH'(CNT_MAX);
    localparam logic [GOOD_W-1:0]      GOOD_TGT = GOOD_W'(VALID_GATES);

    logic [2:0]             sync_ff;
    logic                   edge_ff;
    logic                   edge_det;
    logic [COUNT_WIDTH-1:0] cnt;
    logic [GOOD_W-1:0]      good_cnt;
    logic [GOOD_W-1:0]      good_nxt;
    logic                   in_win;

    // Three-flop synchroniser plus one stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= '0;
            edge_ff <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[1:0], ref_toggle};
            edge_ff <= sync_ff[2];
        end
    end

    assign edge_det = sync_ff[2] ^ edge_ff;
    assign in_win   = (cnt >= WIN_LO) && (cnt <= WIN_HI);

    // Good counter saturates at the target so ch_valid stays up while good.
    always_comb begin
        good_nxt = good_cnt;
        if (good_cnt != GOOD_TGT)
            good_nxt = good_cnt + GOOD_W'(1);
    end

    // Edge counting per gate; the gate tick wins over a coincident edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            ch_count <= '0;
            good_cnt <= '0;
            ch_valid <= 1'b0;
        end else if (gate_tick) begin
            cnt      <= '0;
            ch_count <= cnt;
            if (in_win) begin
                good_cnt <= good_nxt;
                ch_valid <= (good_nxt == GOOD_TGT);
            end else begin
                good_cnt <= '0;
                ch_valid <= 1'b0;
            end
        end else if (edge_det && (cnt != '1)) begin
            cnt <= cnt + COUNT_WIDTH'(1);
        end
    end

endmodule

module ref_clk_select #(
    parameter int N_CH        = 2,
    parameter int GATE_WIDTH  = 8,
    parameter int COUNT_WIDTH = 8,
    parameter int CNT_MIN     = 8,
    parameter int CNT_MAX     = 12,
    parameter int VALID_GATES = 8,
    parameter int HOLDOFF     = 1024,
    localparam int SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_CH-1:0]             ref_toggle,
    input  logic [N_CH-1:0]             ch_ready,
    input  logic                        manual_en,
    input  logic [SEL_W-1:0]            manual_sel,
    output logic [SEL_W-1:0]            sel,
    output logic                        sel_pulse,
    output logic [N_CH-1:0]             ch_valid,
    output logic [N_CH*COUNT_WIDTH-1:0] ch_count,
    output logic                        gate_tick
);

    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLDOFF - 1);

    typedef enum logic {LOCKED, HOLD} state_t;

    state_t              state;
    logic [GATE_WIDTH-1:0] gate_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [N_CH-1:0]     eligible;
    logic [SEL_W-1:0]    cand;
    logic [SEL_W-1:0]    man_target;
    logic [SEL_W-1:0]    target;
    logic                man_q;
    logic                forced;

    // Free-running gate counter; tick is registered so it is low in reset
    // and the first gate after release is a full one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt  <= '0;
            gate_tick <= 1'b0;
        end else begin
            gate_cnt  <= gate_cnt + GATE_WIDTH'(1);
            gate_tick <= (gate_cnt == '1);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ref_clk_select_ch #(
            .COUNT_WIDTH (COUNT_WIDTH),
            .CNT_MIN     (CNT_MIN),
            .CNT_MAX     (CNT_MAX),
            .VALID_GATES (VALID_GATES)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .ref_toggle (ref_toggle[i]),
            .gate_tick  (gate_tick),
            .ch_count   (ch_count[i*COUNT_WIDTH +: COUNT_WIDTH]),
            .ch_valid   (ch_valid[i])
        );
    end

    // Channel 0 is the failsafe and is always eligible.
    assign eligible = (ch_valid & ch_ready) | N_CH'(1);

    // Highest-index eligible channel wins.
    always_comb begin
        cand = '0;
        for (int i = 1; i < N_CH; i++)
            if (eligible[i])
                cand = SEL_W'(i);
    end

    // Out-of-range manual selections fall back to the failsafe channel.
    always_comb begin
        man_target = '0;
        if (32'(manual_sel) < 32'(N_CH))
            man_target = manual_sel;
    end

    assign target = manual_en ? man_target : cand;

    // Immediate switch: manual change, loss of the selected channel, or the
    // first automatic cycle after manual mode ends with a different choice.
    assign forced = manual_en ? (target != sel)
                              : (!eligible[sel] || (man_q && (cand != sel)));

    // Selection FSM; every sel change carries exactly one sel_pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOCKED;
            sel       <= '0;
            sel_pulse <= 1'b0;
            hold_cnt  <= '0;
            man_q     <= 1'b0;
        end else begin
            man_q     <= manual_en;
            sel_pulse <= 1'b0;
            if (forced) begin
                sel       <= target;
                sel_pulse <= 1'b1;
                state     <= HOLD;
                hold_cnt  <= HOLD_RELOAD;
            end else begin
                case (state)
                    LOCKED: begin
                        if (!manual_en && (target != sel)) begin
                            sel       <= target;
                            sel_pulse <= 1'b1;
                            state     <= HOLD;
                            hold_cnt  <= HOLD_RELOAD;
                        end
                    end
                    HOLD: begin
                        if (hold_cnt == '0)
                            state <= LOCKED;
                        else
                            hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                    default: state <= LOCKED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ref_clk_select.sv
// Directed bench for ref_clk_select: default-parameter instance for the
// measurement/selection behaviour, plus a 3-channel instance for manual
// out-of-range mapping.
module tb_ref_clk_select;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ref_toggle;
    logic [1:0]  ch_ready;
    logic        manual_en;
    logic [0:0]  manual_sel;
    logic [0:0]  sel;
    logic        sel_pulse;
    logic [1:0]  ch_valid;
    logic [15:0] ch_count;
    logic        gate_tick;

    logic [2:0]  ref_toggle2;
    logic [2:0]  ch_ready2;
    logic        manual_en2;
    logic [1:0]  manual_sel2;
    logic [1:0]  sel2;
    logic        sel_pulse2;
    logic [2:0]  ch_valid2;
    logic [23:0] ch_count2;
    logic        gate_tick2;

    logic ref1;
    logic rdy1;
    int   tog_period;
    int   pulse_cnt  = 0;
    int   pulse_cnt2 = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    assign ref_toggle  = {ref1, 1'b0};
    assign ch_ready    = {rdy1, 1'b1};
    assign ref_toggle2 = 3'b000;
    assign ch_ready2   = 3'b000;

    always #5 clk = ~clk;

    ref_clk_select dut (
        .clk(clk), .rst_n(rst_n), .ref_toggle(ref_toggle), .ch_ready(ch_ready),
        .manual_en(manual_en), .manual_sel(manual_sel), .sel(sel),
        .sel_pulse(sel_pulse), .ch_valid(ch_valid), .ch_count(ch_count),
        .gate_tick(gate_tick)
    );

    ref_clk_select #(.N_CH(3), .GATE_WIDTH(4), .HOLDOFF(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .ref_toggle(ref_toggle2), .ch_ready(ch_ready2),
        .manual_en(manual_en2), .manual_sel(manual_sel2), .sel(sel2),
        .sel_pulse(sel_pulse2), .ch_valid(ch_valid2), .ch_count(ch_count2),
        .gate_tick(gate_tick2)
    );

    // Pulse counters (sel_pulse seen before the NBA update of this edge).
    always @(posedge clk) begin
        if (sel_pulse)  pulse_cnt  <= pulse_cnt + 1;
        if (sel_pulse2) pulse_cnt2 <= pulse_cnt2 + 1;
    end

    // Channel-1 reference: inverts every tog_period clk cycles; 0 = stopped.
    initial begin
        int tcnt;
        ref1 = 1'b0;
        tcnt = 0;
        forever begin
            @(negedge clk);
            if (tog_period == 0) begin
                tcnt = 0;
            end else begin
                tcnt++;
                if (tcnt >= tog_period) begin
                    ref1 = ~ref1;
                    tcnt = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Returns at the negedge inside the gate_tick cycle.
    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 600 && !seen; k++) begin
            @(negedge clk);
            if (gate_tick) seen = 1'b1;
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL gate_tick_timeout: no tick within 600 cycles");
        end
    endtask

    typedef struct {
        string name;
        int    period;
        bit    ready;
        int    cnt_lo;
        int    cnt_hi;
        int    valid;
        int    sel;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int n;
        int p0;
        bit hit;

        vecs[0] = '{"fast_p10",   10, 1'b1, 25, 26, 0, 0};
        vecs[1] = '{"good_p25",   25, 1'b1, 10, 11, 1, 1};
        vecs[2] = '{"low_p30",    30, 1'b1,  8,  9, 1, 1};
        vecs[3] = '{"high_p22",   22, 1'b1, 11, 12, 1, 1};
        vecs[4] = '{"over_p19",   19, 1'b1, 13, 14, 0, 0};
        vecs[5] = '{"under_p37",  37, 1'b1,  6,  7, 0, 0};
        vecs[6] = '{"notrdy_p25", 25, 1'b0, 10, 11, 1, 0};
        vecs[7] = '{"regood_p25", 25, 1'b1, 10, 11, 1, 1};

        rst_n       = 1'b0;
        rdy1        = 1'b0;
        tog_period  = 0;
        manual_en   = 1'b0;
        manual_sel  = 1'b0;
        manual_en2  = 1'b0;
        manual_sel2 = 2'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sel",       int'(sel), 0);
        chk("rst_sel_pulse", int'(sel_pulse), 0);
        chk("rst_ch_valid",  int'(ch_valid), 0);
        chk("rst_ch_count",  int'(ch_count), 0);
        chk("rst_gate_tick", int'(gate_tick), 0);

        // First gate after release is a full 256 cycles
        rst_n      = 1'b1;
        tog_period = 25;
        n   = 0;
        hit = 1'b0;
        for (int k = 0; k < 600 && !hit; k++) begin
            @(negedge clk);
            n++;
            if (gate_tick) hit = 1'b1;
        end
        chk("first_tick_cycles", n, 256);

        // Qualification takes exactly 8 good gates; ch_ready low keeps sel 0
        for (int t = 2; t <= 7; t++) wait_tick();
        @(negedge clk);
        chk("valid_after_7", int'(ch_valid[1]), 0);
        wait_tick();
        @(negedge clk);
        chk("valid_after_8", int'(ch_valid[1]), 1);
        chk_rng("count_p25", int'(ch_count[15:8]), 10, 11);
        chk("sel_not_ready", int'(sel), 0);

        // Manual on/off, then ch_ready rises during the forced-switch holdoff
        p0 = pulse_cnt;
        manual_en  = 1'b1;
        manual_sel = 1'b1;
        repeat (2) @(negedge clk);
        chk("manual_sel_valid_ch1", int'(sel), 1);
        manual_en = 1'b0;
        @(negedge clk);
        chk("manual_release_forced", int'(sel), 0);
        rdy1 = 1'b1;
        n   = 0;
        hit = 1'b0;
        for (int k = 0; k < 1200 && !hit; k++) begin
            @(negedge clk);
            n++;
            if (sel == 1'b1) hit = 1'b1;
        end
        chk("holdoff_wait_cycles", n, 1025);
        repeat (2) @(negedge clk);
        chk("holdoff_seq_pulses", pulse_cnt - p0, 3);

        // Qualified ch1 stops: fallback to ch0 within 2 cycles of the tick
        wait_tick();
        tog_period = 0;
        p0 = pulse_cnt;
        wait_tick();
        @(negedge clk);
        chk_rng("count_after_stop", int'(ch_count[15:8]), 0, 7);
        chk("valid_after_stop", int'(ch_valid[1]), 0);
        @(negedge clk);
        chk("sel_after_stop", int'(sel), 0);
        @(negedge clk);
        chk("stop_pulses", pulse_cnt - p0, 1);
        wait_tick();
        @(negedge clk);
        chk("count_dead", int'(ch_count[15:8]), 0);

        // Manual select of a dead channel, unchanged target, release
        p0 = pulse_cnt;
        manual_en  = 1'b1;
        manual_sel = 1'b1;
        repeat (3) @(negedge clk);
        chk("manual_dead_sel", int'(sel), 1);
        chk("manual_dead_pulse", pulse_cnt - p0, 1);
        repeat (5) @(negedge clk);
        chk("manual_hold_no_pulse", pulse_cnt - p0, 1);
        manual_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("manual_off_sel", int'(sel), 0);
        chk("manual_off_pulse", pulse_cnt - p0, 2);

        // Out-of-range manual_sel maps to channel 0 (3-channel instance)
        manual_en2  = 1'b1;
        manual_sel2 = 2'd3;
        repeat (3) @(negedge clk);
        chk("n3_sel3_is_0", int'(sel2), 0);
        chk("n3_sel3_no_pulse", pulse_cnt2, 0);
        manual_sel2 = 2'd2;
        repeat (3) @(negedge clk);
        chk("n3_sel2", int'(sel2), 2);
        chk("n3_sel2_pulse", pulse_cnt2, 1);
        manual_sel2 = 2'd3;
        repeat (3) @(negedge clk);
        chk("n3_sel3_back_0", int'(sel2), 0);
        chk("n3_sel3_pulse", pulse_cnt2, 2);
        manual_en2 = 1'b0;

        // Steady-state measurement vectors
        for (int v = 0; v < 8; v++) begin
            tog_period = vecs[v].period;
            rdy1       = vecs[v].ready;
            repeat (9) wait_tick();
            repeat (2) @(negedge clk);
            chk_rng({vecs[v].name, "_count"}, int'(ch_count[15:8]), vecs[v].cnt_lo, vecs[v].cnt_hi);
            chk({vecs[v].name, "_valid"}, int'(ch_valid[1]), vecs[v].valid);
            chk({vecs[v].name, "_sel"},   int'(sel), vecs[v].sel);
        end

        // Reset while ch1 selected, then full requalification
        rst_n = 1'b0;
        #1;
        chk("midrst_sel",      int'(sel), 0);
        chk("midrst_ch_valid", int'(ch_valid), 0);
        chk("midrst_ch_count", int'(ch_count), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int t = 1; t <= 7; t++) wait_tick();
        @(negedge clk);
        chk("requal_after_7", int'(ch_valid[1]), 0);
        wait_tick();
        @(negedge clk);
        chk("requal_after_8", int'(ch_valid[1]), 1);
        @(negedge clk);
        chk("requal_sel", int'(sel), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
